// File: rtl/iomem_sample_fifo.sv
// Memory-mapped stereo sample FIFO: firmware pushes words over iomem, the codec
// stage pops one word per sample_req, and irq_low requests a refill at low level.
module iomem_sample_fifo #(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          DEPTH_LOG2 = 8,
    parameter bit          BLOCKING   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic        sample_req,
    output logic [31:0] sample_out,
    output logic        sample_valid,
    output logic        irq_low
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_LVL  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] ONE_PTR = DEPTH_LOG2'(1);

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic                  en, unf, ovf;
    logic [7:0]            thresh;

    logic        sel, is_wr, full, empty;
    logic [1:0]  reg_off;
    logic        data_wr, stat_wr, ctrl_wr, flush;
    logic        pop_ok, unf_set, push, stall, ovf_set, ack;
    logic [8:0]  level9;
    logic [31:0] rdata_nxt;
    logic        unused;

    assign unused = ^iomem_addr[1:0];

    // The cycle ready is high is never a new select, so acks cannot run back to back.
    assign sel     = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]) && !iomem_ready;
    assign is_wr   = |iomem_wstrb;
    assign reg_off = iomem_addr[3:2];
    assign data_wr = sel && is_wr && (reg_off == 2'd0);
    assign stat_wr = sel && is_wr && (reg_off == 2'd1);
    assign ctrl_wr = sel && is_wr && (reg_off == 2'd2);
    assign flush   = ctrl_wr && iomem_wstrb[0] && iomem_wdata[1];

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign level9  = 9'(level);

    // A pop coinciding with a flush plays silence, exactly as if EN were clear.
    assign pop_ok  = sample_req && en && !flush && !empty;
    assign unf_set = sample_req && en && !flush && empty;
    assign push    = data_wr && (!full || pop_ok);
    assign stall   = BLOCKING && data_wr && full && !pop_ok;
    assign ovf_set = !BLOCKING && data_wr && full && !pop_ok;
    assign ack     = sel && !stall;

    always_comb begin
        rdata_nxt = '0;
        if (!is_wr) begin
            case (reg_off)
                2'd1:    rdata_nxt = {6'b0, ovf, unf, 6'b0, full, empty, 7'b0, level9};
                2'd2:    rdata_nxt = {8'b0, thresh, 15'b0, en};
                default: rdata_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= iomem_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iomem_ready  <= 1'b0;
            iomem_rdata  <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            irq_low      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            en           <= 1'b0;
            thresh       <= '0;
            unf          <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            iomem_ready  <= ack;
            iomem_rdata  <= ack ? rdata_nxt : '0;
            sample_valid <= sample_req;
            if (sample_req) sample_out <= pop_ok ? mem[rd_ptr] : '0;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push)   wr_ptr <= wr_ptr + ONE_PTR;
                if (pop_ok) rd_ptr <= rd_ptr + ONE_PTR;
                if (push && !pop_ok)      level <= level + ONE_LVL;
                else if (pop_ok && !push) level <= level - ONE_LVL;
            end

            if (ctrl_wr) begin
                if (iomem_wstrb[0]) en     <= iomem_wdata[0];
                if (iomem_wstrb[2]) thresh <= iomem_wdata[23:16];
            end

            // Set beats a simultaneous write-1-to-clear.
            unf <= unf_set | (unf & ~(stat_wr & iomem_wdata[24]));
            ovf <= ovf_set | (ovf & ~(stat_wr & iomem_wdata[25]));

            irq_low <= en && (level9 <= {1'b0, thresh});
        end
    end
endmodule

// File: tb/tb_iomem_sample_fifo.sv
// Bench for iomem_sample_fifo: register table, directed corner sequences and
// randomized push/pop traffic against a queue-based model.
module tb_iomem_sample_fifo;
    localparam logic [31:0] BASE  = 32'h0300_0000;
    localparam int          DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       valid = '0, sreq = '0;
    logic [1:0]       ready, svld, irq;
    logic [1:0][31:0] rdata, sout;
    logic [3:0]       wstrb = '0;
    logic [31:0]      addr = '0, wdata = '0;

    iomem_sample_fifo #(.BASE_ADDR(BASE), .DEPTH_LOG2(8), .BLOCKING(1'b1)) dut0 (
        .clk(clk), .reset(rst), .iomem_valid(valid[0]), .iomem_ready(ready[0]),
        .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata[0]),
        .sample_req(sreq[0]), .sample_out(sout[0]), .sample_valid(svld[0]), .irq_low(irq[0]));

    iomem_sample_fifo #(.BASE_ADDR(BASE), .DEPTH_LOG2(2), .BLOCKING(1'b0)) dut1 (
        .clk(clk), .reset(rst), .iomem_valid(valid[1]), .iomem_ready(ready[1]),
        .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata[1]),
        .sample_req(sreq[1]), .sample_out(sout[1]), .sample_valid(svld[1]), .irq_low(irq[1]));

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model of dut0
    logic [31:0] q[$];
    bit          m_en, m_unf, m_ovf;
    logic [7:0]  m_thr;

    typedef struct {
        logic [31:0] off;
        logic [3:0]  ws;
        logic [31:0] wd;
        bit          is_rd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic bus(input int d, input logic [31:0] off, input logic [3:0] ws,
                       input logic [31:0] wd, output logic [31:0] rd);
        int n;
        @(negedge clk);
        valid[d] = 1'b1; addr = BASE + off; wstrb = ws; wdata = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready[d] && n < 20);
        chk("bus_ack", {31'b0, ready[d]}, 32'd1);
        rd = rdata[d];
        valid[d] = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        logic [31:0] rd;
        bus(0, 32'h0, 4'hF, w, rd);
        q.push_back(w);
    endtask

    task automatic pop();
        logic [31:0] e;
        @(negedge clk); sreq[0] = 1'b1;
        @(negedge clk); sreq[0] = 1'b0;
        if (m_en && q.size() > 0) e = q.pop_front();
        else begin
            e = '0;
            if (m_en) m_unf = 1'b1;
        end
        chk("sample_valid", {31'b0, svld[0]}, 32'd1);
        chk("sample_out", sout[0], e);
    endtask

    function automatic logic [31:0] exp_status();
        int l = q.size();
        return {6'b0, m_ovf, m_unf, 6'b0, l == DEPTH, l == 0, 7'b0, 9'(l)};
    endfunction

    task automatic check_status(input string name);
        logic [31:0] rd;
        bus(0, 32'h4, 4'h0, 32'h0, rd);
        chk(name, rd, exp_status());
    endtask

    task automatic check_irq(input string name);
        @(negedge clk);
        chk(name, {31'b0, irq[0]}, {31'b0, m_en && (q.size() <= int'(m_thr))});
    endtask

    task automatic fill_full();
        while (q.size() < DEPTH) push($urandom | 32'h1);
    endtask

    initial begin
        logic [31:0] rd, w;
        bit seen;
        int r;

        tbl[0] = '{32'h4, 4'h0, 32'h0,          1, 32'h0001_0000};
        tbl[1] = '{32'h8, 4'h0, 32'h0,          1, 32'h0};
        tbl[2] = '{32'hC, 4'h0, 32'h0,          1, 32'h0};
        tbl[3] = '{32'h8, 4'hF, 32'h0004_0003,  0, 32'h0};
        tbl[4] = '{32'h8, 4'h0, 32'h0,          1, 32'h0004_0001};
        tbl[5] = '{32'hC, 4'hF, 32'hFFFF_FFFF,  0, 32'h0};
        tbl[6] = '{32'hC, 4'h0, 32'h0,          1, 32'h0};
        tbl[7] = '{32'h0, 4'h0, 32'h0,          1, 32'h0};
        tbl[8] = '{32'h8, 4'h1, 32'h0009_0001,  0, 32'h0};
        tbl[9] = '{32'h8, 4'h0, 32'h0,          1, 32'h0004_0001};
        m_en = 0; m_unf = 0; m_ovf = 0; m_thr = 0;

        // Reset values
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", {31'b0, ready[d]}, 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
            chk("rst_sout", sout[d], 32'd0);
            chk("rst_svld", {31'b0, svld[d]}, 32'd0);
            chk("rst_irq", {31'b0, irq[d]}, 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            bus(0, tbl[i].off, tbl[i].ws, tbl[i].wd, rd);
            if (tbl[i].is_rd) chk($sformatf("tbl%0d", i), rd, tbl[i].exp);
        end
        m_en = 1; m_thr = 8'd4;
        check_irq("irq_empty");

        // Threshold crossing
        for (int i = 0; i < 3; i++) push(32'h100 + i);
        check_status("status_lvl3");
        check_irq("irq_lvl3");
        push(32'h200); push(32'h201);
        check_irq("irq_lvl5");
        check_status("status_lvl5");
        while (q.size() > 0) pop();

        // Ordering
        push(32'hAAAA_5555); push(32'h1234_5678);
        pop(); pop();
        check_status("status_drained");

        // Underflow and W1C
        pop();
        check_status("status_unf");
        bus(0, 32'h4, 4'hF, 32'h0100_0000, rd);
        m_unf = 0;
        check_status("status_unf_clr");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                if (q.size() < DEPTH) push($urandom);
            end else if (r <= 6) pop();
            else if (r == 7) check_status("rnd_status");
            else if (r == 8) check_irq("rnd_irq");
            else begin
                m_thr = 8'($urandom_range(0, 12));
                m_en  = ($urandom_range(0, 3) != 0);
                bus(0, 32'h8, 4'b0101, {8'b0, m_thr, 15'b0, m_en}, rd);
            end
        end
        m_en = 1; m_thr = 8'd4;
        bus(0, 32'h8, 4'b0101, 32'h0004_0001, rd);
        bus(0, 32'h4, 4'hF, 32'h0300_0000, rd);
        m_unf = 0; m_ovf = 0;
        check_status("status_after_rnd");
        while (q.size() > 0) pop();

        // Blocking stall on full FIFO
        fill_full();
        check_status("status_full");
        w = 32'hCAFE_0001;
        @(negedge clk);
        valid[0] = 1'b1; addr = BASE; wstrb = 4'hF; wdata = w; seen = 0;
        repeat (5) begin @(negedge clk); if (ready[0]) seen = 1; end
        chk("stall_ready_low", {31'b0, seen}, 32'd0);
        sreq[0] = 1'b1;
        @(negedge clk);
        sreq[0] = 1'b0;
        chk("stall_ack", {31'b0, ready[0]}, 32'd1);
        chk("stall_pop", sout[0], q[0]);
        valid[0] = 1'b0;
        void'(q.pop_front());
        q.push_back(w);
        check_status("status_full_after_stall");
        while (q.size() > 0) pop();

        // Non-blocking drop on dut1 (depth 4)
        bus(1, 32'h8, 4'hF, 32'h0000_0001, rd);
        for (int i = 1; i <= 5; i++) bus(1, 32'h0, 4'hF, i, rd);
        bus(1, 32'h4, 4'h0, 32'h0, rd);
        chk("nb_status", rd, 32'h0202_0004);
        @(negedge clk); sreq[1] = 1'b1;
        @(negedge clk); sreq[1] = 1'b0;
        chk("nb_pop", sout[1], 32'd1);

        // FLUSH with same-cycle pop
        for (int i = 0; i < 10; i++) push(32'h5000 + i);
        pop();
        @(negedge clk);
        valid[0] = 1'b1; addr = BASE + 32'h8; wstrb = 4'h1; wdata = 32'h3; sreq[0] = 1'b1;
        @(negedge clk);
        sreq[0] = 1'b0;
        chk("flush_ack", {31'b0, ready[0]}, 32'd1);
        chk("flush_svld", {31'b0, svld[0]}, 32'd1);
        chk("flush_sout", sout[0], 32'd0);
        valid[0] = 1'b0;
        q.delete();
        check_status("status_flushed");
        bus(0, 32'h8, 4'h0, 32'h0, rd);
        chk("ctrl_after_flush", rd, 32'h0004_0001);

        // Reset during a stalled write
        fill_full();
        pop();
        push(32'h7777_0001);
        @(negedge clk);
        valid[0] = 1'b1; addr = BASE; wstrb = 4'hF; wdata = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        rst = 1'b1; valid[0] = 1'b0;
        @(negedge clk);
        chk("rst2_ready", {31'b0, ready[0]}, 32'd0);
        chk("rst2_sout", sout[0], 32'd0);
        chk("rst2_irq", {31'b0, irq[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        q.delete(); m_en = 0; m_thr = 0; m_unf = 0; m_ovf = 0;
        check_status("status_after_rst");
        push(32'h0BAD_F00D);
        check_status("status_push_after_rst");
        check_irq("irq_after_rst");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
